// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared state encoding and geometry defaults for the icache refill path
package icache_refill_pkg;
  localparam int ADDR_WIDTH_DEF = 17;
  localparam int BLOCK_WIDTH_DEF = 4;
  localparam int RAM_READ_LATENCY = 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT_GRANT = 3'd1,
    READ = 3'd2,
    DRAIN = 3'd3,
    DONE = 3'd4
  } state_t;
endpackage

// File: rtl/icache_refill_line_buffer.sv
// refill_line_buffer: byte-indexed write port with full-line read of the refill buffer
module refill_line_buffer #(
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [BLOCK_WIDTH-1:0]        idx,
  input  logic [7:0]                    wdata,
  output logic [8*(2**BLOCK_WIDTH)-1:0] line
);
  always_ff @(posedge clk)
    if (rst) line <= '0;
    else if (we) line[8*idx +: 8] <= wdata;
endmodule

// File: rtl/icache_refill.sv
// icache_refill: fetches one cache line byte-wise from RAM and delivers it as a single-cycle block write
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH
) (
  input  logic                        clkIn,
  input  logic                        resetIn,
  input  logic                        missValid,
  input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] missAddr,
  input  logic                        flushIn,
  output logic                        busy,
  output logic                        memDataValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0]     memDataIn,
  output logic                        ramReq,
  input  logic                        ramGrant,
  output logic                        ramReadEnable,
  output logic [ADDR_WIDTH-1:0]       ramAddrOut,
  input  logic [7:0]                  ramDataIn
);
  state_t state;
  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] line_addr;
  logic [BLOCK_WIDTH-1:0] issue_cnt;
  logic [BLOCK_WIDTH:0] rx_cnt;
  logic pending;
  logic buf_we;
  always_comb begin
    busy = state != IDLE;
    ramReq = (state == WAIT_GRANT) || (state == READ) || (state == DRAIN);
    ramReadEnable = (state == READ) && ramGrant;
    ramAddrOut = {line_addr, issue_cnt};
    memDataValid = (state == DONE) && !flushIn;
    memAddr = line_addr;
    buf_we = pending && !rx_cnt[BLOCK_WIDTH] && !flushIn;
  end
  always_ff @(posedge clkIn)
    if (resetIn) begin
      state <= IDLE;
      line_addr <= '0;
      issue_cnt <= '0;
      rx_cnt <= '0;
      pending <= 1'b0;
    end else begin
      pending <= (state == READ) && ramGrant && !flushIn;
      rx_cnt <= pending ? rx_cnt + 1'b1 : rx_cnt;
      if (flushIn) state <= IDLE;
      else
        case (state)
          IDLE:
            if (missValid) begin
              line_addr <= missAddr;
              issue_cnt <= '0;
              rx_cnt <= '0;
              state <= WAIT_GRANT;
            end
          WAIT_GRANT: state <= ramGrant ? READ : WAIT_GRANT;
          READ:
            if (ramGrant) begin
              issue_cnt <= issue_cnt + 1'b1;
              state <= (&issue_cnt) ? DRAIN : READ;
            end
          DRAIN: state <= DONE;
          default: state <= IDLE;
        endcase
    end
  refill_line_buffer #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_buf (
    .clk(clkIn),
    .rst(resetIn),
    .we(buf_we),
    .idx(rx_cnt[BLOCK_WIDTH-1:0]),
    .wdata(ramDataIn),
    .line(memDataIn)
  );
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: scoreboard bench for the icache line refill engine
module tb_icache_refill;
  localparam int AW = 17;
  localparam int BW = 4;
  localparam int BS = 16;
  localparam int LW = AW - BW;
  localparam logic [8*BS-1:0] LINE_012 = 128'h2F2E2D2C2B2A29282726252423222120;
  typedef struct {
    logic [LW-1:0] a;
    logic [8*BS-1:0] d;
    int c;
  } exp_t;
  logic clkIn = 1'b0;
  logic resetIn = 1'b1;
  logic missValid = 1'b0;
  logic flushIn = 1'b0;
  logic gnt_en = 1'b1;
  logic [LW-1:0] missAddr = '0;
  logic busy, memDataValid, ramReq, ramGrant, ramReadEnable;
  logic [LW-1:0] memAddr;
  logic [8*BS-1:0] memDataIn;
  logic [AW-1:0] ramAddrOut;
  logic [7:0] ramDataIn = '0;
  exp_t sb[$];
  logic [AW-1:0] issued[$];
  int cyc = 0;
  int pass = 0;
  int total = 0;
  icache_refill #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .clkIn(clkIn),
    .resetIn(resetIn),
    .missValid(missValid),
    .missAddr(missAddr),
    .flushIn(flushIn),
    .busy(busy),
    .memDataValid(memDataValid),
    .memAddr(memAddr),
    .memDataIn(memDataIn),
    .ramReq(ramReq),
    .ramGrant(ramGrant),
    .ramReadEnable(ramReadEnable),
    .ramAddrOut(ramAddrOut),
    .ramDataIn(ramDataIn)
  );
  always #5 clkIn = ~clkIn;
  assign ramGrant = ramReq & gnt_en;
  always @(posedge clkIn) begin
    cyc <= cyc + 1;
    if (ramReadEnable) ramDataIn <= ramAddrOut[7:0];
  end
  function automatic logic [8*BS-1:0] line_of(input logic [LW-1:0] a);
    logic [AW-1:0] b;
    line_of = '0;
    for (int i = 0; i < BS; i++) begin
      b = {a, BW'(i)};
      line_of[8*i +: 8] = b[7:0];
    end
  endfunction
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
  endtask
  task automatic step();
    @(posedge clkIn);
    #1;
  endtask
  task automatic miss(input logic [LW-1:0] a, input bit expect_pulse, input int lat,
                      input logic [8*BS-1:0] d, output int c0);
    step();
    c0 = cyc;
    missValid = 1'b1;
    missAddr = a;
    if (expect_pulse) sb.push_back('{a, d, c0 + lat});
    step();
    missValid = 1'b0;
  endtask
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    step();
  endtask
  task automatic outs_zero(input string n);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_valid"}, memDataValid, 0);
    chk({n, "_req"}, ramReq, 0);
    chk({n, "_ren"}, ramReadEnable, 0);
    chk({n, "_maddr"}, memAddr, 0);
    chk({n, "_mdata"}, memDataIn, 0);
    chk({n, "_raddr"}, ramAddrOut, 0);
  endtask
  always @(negedge clkIn) begin
    exp_t e;
    if (ramReadEnable === 1'b1) issued.push_back(ramAddrOut);
    if (memDataValid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got addr %0h want no pulse (cycle %0d)", memAddr, cyc);
      end else begin
        e = sb.pop_front();
        chk("pulse_addr", memAddr, e.a);
        chk("pulse_data", memDataIn, e.d);
        chk("pulse_cycle", cyc, e.c);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (3) step();
    resetIn = 1'b0;
    @(negedge clkIn);
    outs_zero("reset");
    miss(13'h012, 1, 19, LINE_012, c);
    wait_drain(60);
    @(negedge clkIn);
    chk("basic_req_after", ramReq, 0);
    chk("basic_busy_after", busy, 0);
    issued.delete();
    gnt_en = 1'b0;
    miss(13'h012, 1, 27, LINE_012, c);
    while (cyc < c + 30) begin
      gnt_en = !((cyc - c) <= 5 || ((cyc - c) >= 14 && (cyc - c) <= 16));
      if ((cyc - c) == 3) begin
        #1;
        chk("stall_wait_ren", ramReadEnable, 0);
        chk("stall_wait_req", ramReq, 1);
      end
      if ((cyc - c) == 15) begin
        #1;
        chk("stall_gap_ren", ramReadEnable, 0);
        chk("stall_gap_req", ramReq, 1);
      end
      step();
    end
    gnt_en = 1'b1;
    wait_drain(20);
    chk("stall_issue_count", issued.size(), 16);
    for (int i = 0; i < 16; i++) chk("stall_issue_addr", issued[i], 17'h120 + 17'(i));
    miss(13'h0AB, 0, 0, '0, c);
    while (cyc < c + 12) step();
    flushIn = 1'b1;
    step();
    flushIn = 1'b0;
    @(negedge clkIn);
    chk("flush_req", ramReq, 0);
    chk("flush_busy", busy, 0);
    miss(13'h013, 1, 19, line_of(13'h013), c);
    wait_drain(60);
    miss(13'h021, 1, 19, line_of(13'h021), c);
    while (cyc < c + 8) step();
    missValid = 1'b1;
    missAddr = 13'h033;
    step();
    step();
    missValid = 1'b0;
    wait_drain(60);
    repeat (25) step();
    chk("busy_miss_ignored", busy, 0);
    step();
    missValid = 1'b1;
    flushIn = 1'b1;
    missAddr = 13'h044;
    step();
    missValid = 1'b0;
    flushIn = 1'b0;
    @(negedge clkIn);
    chk("flushmiss_busy", busy, 0);
    chk("flushmiss_req", ramReq, 0);
    repeat (3) step();
    chk("flushmiss_busy_later", busy, 0);
    miss(13'h040, 0, 0, '0, c);
    while (cyc < c + 18) step();
    chk("drain_ren", ramReadEnable, 0);
    chk("drain_req", ramReq, 1);
    resetIn = 1'b1;
    step();
    resetIn = 1'b0;
    @(negedge clkIn);
    outs_zero("rstdrain");
    miss(13'h055, 1, 19, line_of(13'h055), c);
    wait_drain(60);
    miss(13'h066, 0, 0, '0, c);
    while (cyc < c + 19) step();
    flushIn = 1'b1;
    #1;
    chk("done_flush_valid", memDataValid, 0);
    chk("done_flush_busy", busy, 1);
    step();
    flushIn = 1'b0;
    @(negedge clkIn);
    chk("done_flush_idle", busy, 0);
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
